// File: rtl/cv32e40s_mul_issue_pkg.sv
// Operator encoding shared by the multiply issue register and the multiplier.
package cv32e40s_mul_issue_pkg;

    typedef enum logic [0:0] {
        MUL_M32 = 1'b0,
        MUL_H   = 1'b1
    } mul_opcode_e;

endpackage

// File: rtl/cv32e40s_mul_issue.sv
// Issue register in front of cv32e40s_mult: captures M-extension multiply ops and holds them for the multiplier.
// Optional saturating stall counter enabled by defining MUL_ISSUE_STALL_CNT_EN.
module cv32e40s_mul_issue
    import cv32e40s_mul_issue_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       rs1_i,
    input  logic [31:0]       rs2_i,
    input  logic              halt_i,
    input  logic              kill_i,
    output logic              mult_valid_o,
    output mul_opcode_e       mult_operator_o,
    output logic [1:0]        mult_signed_mode_o,
    output logic [31:0]       mult_op_a_o,
    output logic [31:0]       mult_op_b_o,
    output logic              mult_halt_o,
    output logic              mult_kill_o,
    input  logic              mult_ready_i,
`ifdef MUL_ISSUE_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
`endif
    output logic              err_o
);

    logic        valid_q, valid_d;
    mul_opcode_e op_q, op_d;
    logic [1:0]  sm_q, sm_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        err_q, err_d;

    logic handshake;
    logic accept;
    logic retire;

    assign id_ready_o = !halt_i && !kill_i && (!valid_q || mult_ready_i);
    assign handshake  = id_valid_i && id_ready_o;
    assign accept     = handshake && !funct3_i[2];
    assign retire     = valid_q && mult_ready_i && !halt_i;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        sm_d    = sm_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = handshake && funct3_i[2];

        // kill overrides everything, halt freezes; accept already excludes both
        if (kill_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            a_d     = rs1_i;
            b_d     = rs2_i;
            op_d    = (funct3_i[1:0] == 2'b00) ? MUL_M32 : MUL_H;
            unique case (funct3_i[1:0])
                2'b01:   sm_d = 2'b11;
                2'b10:   sm_d = 2'b01;
                default: sm_d = 2'b00;
            endcase
        end else if (retire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op_q    <= MUL_M32;
            sm_q    <= 2'b00;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            sm_q    <= sm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

`ifdef MUL_ISSUE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_q && !mult_ready_i && !halt_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign mult_valid_o       = valid_q;
    assign mult_operator_o    = op_q;
    assign mult_signed_mode_o = sm_q;
    assign mult_op_a_o        = a_q;
    assign mult_op_b_o        = b_q;
    assign mult_halt_o        = halt_i;
    assign mult_kill_o        = kill_i;
    assign err_o              = err_q;

endmodule
